// File: rtl/npc_wb_pkg.sv
// Shared constants for the NPC writeback stage: RV32I load encodings,
// writeback source tags and the ALU starvation limit.
package npc_wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] STARVE_MAX = 2'd3;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Combinational load extender: selects the byte or halfword addressed by
// addr_lo_i and sign- or zero-extends it according to the RV32I funct3.
module load_ext
  import npc_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Halfword selection only looks at addr_lo_i[1]; misaligned halves are not supported.
  always_comb begin
    byteSel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byteSel = rdata_i[7:0];
      2'd1:    byteSel = rdata_i[15:8];
      2'd2:    byteSel = rdata_i[23:16];
      default: byteSel = rdata_i[31:24];
    endcase
    halfSel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      LB:      data_o = {{(DATA_WIDTH-8){byteSel[7]}}, byteSel};
      LH:      data_o = {{(DATA_WIDTH-16){halfSel[15]}}, halfSel};
      LW:      data_o = rdata_i;
      LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, byteSel};
      LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, halfSel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// NPC writeback stage: arbitrates ALU and LSU results onto the single register
// file write port (one cycle after acceptance) and tracks pending loads.
module wb_stage
  import npc_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         lsu_issue,
  input  logic [ADDR_WIDTH-1:0]        lsu_issue_rd,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [ADDR_WIDTH-1:0]        lsu_rd,
  input  logic [DATA_WIDTH-1:0]        lsu_rdata,
  input  logic [1:0]                   lsu_addr_lo,
  input  logic [2:0]                   lsu_funct3,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic [(2**ADDR_WIDTH)-1:0]   pending
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  aluFire;
  logic                  lsuFire;
  logic [DATA_WIDTH-1:0] loadData;

  logic [1:0]            starve_q,   starve_d;
  logic                  rf_wen_q,   rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  src_e                  src_q,      src_d;
  logic [NUM_REGS-1:0]   pending_q,  pending_d;

  load_ext #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_ext (
    .rdata_i   (lsu_rdata),
    .addr_lo_i (lsu_addr_lo),
    .funct3_i  (lsu_funct3),
    .data_o    (loadData)
  );

  // LSU wins unless the ALU has already lost STARVE_MAX grants in a row.
  always_comb begin
    lsu_ready = !rst && lsu_valid && !(alu_valid && starve_q == STARVE_MAX);
    alu_ready = !rst && !lsu_ready;
    aluFire   = alu_valid && alu_ready;
    lsuFire   = lsu_valid && lsu_ready;
  end

  always_comb begin
    starve_d   = (lsuFire && alu_valid) ? starve_q + 2'd1 : 2'd0;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    src_d      = src_q;
    if (lsuFire) begin
      rf_wen_d   = (lsu_rd != '0);
      rf_waddr_d = lsu_rd;
      rf_wdata_d = loadData;
      src_d      = SRC_LSU;
    end else if (aluFire) begin
      rf_wen_d   = (alu_rd != '0);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
      src_d      = SRC_ALU;
    end
  end

  // Clear on LSU commit first so a same-edge re-issue of that register keeps it set.
  always_comb begin
    pending_d = pending_q;
    if (rf_wen_q && src_q == SRC_LSU) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (lsu_issue && lsu_issue_rd != '0) begin
      pending_d[lsu_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      src_q      <= SRC_ALU;
      pending_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      src_q      <= src_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-extension vector table, scoreboard of
// expected writebacks, and hand sequences for reset, scoreboard and arbitration.
module tb_wb_stage;
  import npc_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_addr_lo;
  logic [2:0]  lsu_funct3;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  wb_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
    .lsu_addr_lo(lsu_addr_lo), .lsu_funct3(lsu_funct3),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] rdata;
    logic [31:0] expData;
  } ld_vec_t;

  wb_t     expQ[$];
  ld_vec_t ldTbl[10];

  int          checks = 0;
  int          passes = 0;
  int          mStarve = 0;
  logic [31:0] mPending = '0;
  logic        mCommitLsu = 1'b0;
  logic [4:0]  mCommitAddr = '0;
  logic        sampledLsuRdy;

  // Independent reference for load extension, written with shifts rather than a select table.
  function automatic logic [31:0] extModel(logic [31:0] w, logic [1:0] a, logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (int'(a) * 8)) & 32'hFF);
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Drives one cycle from a negedge, updates the model, and checks the edge that follows.
  task automatic applyStimulus(input logic aluV, input logic [4:0] aluRd, input logic [31:0] aluD,
                               input logic lsuV, input logic [4:0] lsuRd, input logic [31:0] rdata,
                               input logic [1:0] lo, input logic [2:0] f3,
                               input logic issue, input logic [4:0] issueRd);
    logic        expLsu;
    logic [31:0] nextPend;
    wb_t         e;
    alu_valid = aluV;  alu_rd = aluRd;  alu_data = aluD;
    lsu_valid = lsuV;  lsu_rd = lsuRd;  lsu_rdata = rdata;
    lsu_addr_lo = lo;  lsu_funct3 = f3;
    lsu_issue = issue; lsu_issue_rd = issueRd;
    #1;
    expLsu = lsuV && !(aluV && mStarve == 3);
    sampledLsuRdy = lsu_ready;
    checkOutput("lsu_ready", lsu_ready, expLsu);
    checkOutput("alu_ready", alu_ready, !expLsu);
    nextPend = mPending;
    if (mCommitLsu) nextPend[mCommitAddr] = 1'b0;
    if (issue && issueRd != 0) nextPend[issueRd] = 1'b1;
    mCommitLsu = 1'b0;
    if (expLsu) begin
      if (lsuRd != 0) begin
        expQ.push_back('{addr: lsuRd, data: extModel(rdata, lo, f3)});
        mCommitLsu  = 1'b1;
        mCommitAddr = lsuRd;
      end
    end else if (aluV && aluRd != 0) begin
      expQ.push_back('{addr: aluRd, data: aluD});
    end
    mStarve  = (expLsu && aluV) ? mStarve + 1 : 0;
    mPending = nextPend;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rf_wen", rf_wen, 1'b1);
      checkOutput("rf_waddr", rf_waddr, e.addr);
      checkOutput("rf_wdata", rf_wdata, e.data);
    end else begin
      checkOutput("rf_wen_idle", rf_wen, 1'b0);
    end
    checkOutput("pending", pending, mPending);
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b0, 5'd0);
  endtask

  task automatic resetModel();
    expQ.delete();
    mStarve     = 0;
    mPending    = '0;
    mCommitLsu  = 1'b0;
    mCommitAddr = '0;
  endtask

  logic [14:0] arbAluV;
  logic [14:0] arbExp;

  initial begin
    ldTbl[0] = '{LB,     2'd1, 32'h80FF7F01, 32'h0000007F};
    ldTbl[1] = '{LBU,    2'd2, 32'h80FF7F01, 32'h000000FF};
    ldTbl[2] = '{LH,     2'd2, 32'h80FF7F01, 32'hFFFF80FF};
    ldTbl[3] = '{LHU,    2'd0, 32'h80FF7F01, 32'h00007F01};
    ldTbl[4] = '{LW,     2'd1, 32'h80FF7F01, 32'h80FF7F01};
    ldTbl[5] = '{LB,     2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    ldTbl[6] = '{LH,     2'd3, 32'h80FF7F01, 32'hFFFF80FF};
    ldTbl[7] = '{LBU,    2'd0, 32'h80FF7F01, 32'h00000001};
    ldTbl[8] = '{LHU,    2'd2, 32'h80FF7F01, 32'h000080FF};
    ldTbl[9] = '{3'b011, 2'd2, 32'h80FF7F01, 32'h80FF7F01};

    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = '0; alu_data = '0;
    lsu_issue = 1'b0; lsu_issue_rd = '0;
    lsu_valid = 1'b1; lsu_rd = '0; lsu_rdata = '0; lsu_addr_lo = '0; lsu_funct3 = LW;
    #2;
    checkOutput("reset_rf_wen", rf_wen, 1'b0);
    checkOutput("reset_pending", pending, 32'h0);
    checkOutput("reset_alu_ready", alu_ready, 1'b0);
    checkOutput("reset_lsu_ready", lsu_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Single ALU write, then an rd == 0 write that must handshake but not write.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b0, 5'd0);
    checkOutput("alu_wr_addr", rf_waddr, 5'd5);
    checkOutput("alu_wr_data", rf_wdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b0, 5'd0);
    checkOutput("x0_no_wen", rf_wen, 1'b0);

    // Load extension vectors.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, ldTbl[i].rdata, ldTbl[i].lo, ldTbl[i].f3,
                    1'b0, 5'd0);
      checkOutput($sformatf("load_tbl%0d", i), rf_wdata, ldTbl[i].expData);
    end
    idle();

    // Pending scoreboard: set, clear one edge after acceptance, re-issue on the clear edge.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b1, 5'd8);
    checkOutput("pend_set", pending, 32'h0000_0100);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h55AA55AA, 2'd0, LW, 1'b0, 5'd0);
    checkOutput("pend_hold_n", pending[8], 1'b1);
    idle();
    checkOutput("pend_clr_n1", pending[8], 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b1, 5'd8);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h01020304, 2'd0, LW, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b1, 5'd8);
    checkOutput("pend_reissue", pending[8], 1'b1);
    idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h0, 2'd0, LW, 1'b0, 5'd0);
    idle();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b1, 5'd0);
    checkOutput("pend_x0", pending, 32'h0);

    // Arbitration: LSU x3 then ALU, and the starve count clears when ALU idles.
    arbAluV = 15'b111101111111111;
    arbExp  = 15'b011111101110111;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(arbAluV[i], 5'd11, 32'hA000_0000 + i, 1'b1, 5'd10, 32'h1111_0000 + i,
                    2'd0, LW, 1'b0, 5'd0);
      checkOutput($sformatf("arb_grant%0d", i), sampledLsuRdy, arbExp[i]);
    end
    idle();

    // Back-to-back ALU writebacks with distinct destinations.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 5'(i + 1), $urandom, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b0, 5'd0);
    end
    idle();

    // Reset mid-stream with a load pending and a writeback in flight.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b1, 5'd8);
    applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'h0, 2'd0, LW, 1'b0, 5'd0);
    checkOutput("pre_rst_pending", pending, 32'h0000_0100);
    alu_valid = 1'b1; alu_rd = 5'd4; lsu_valid = 1'b1; lsu_rd = 5'd6;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rf_wen", rf_wen, 1'b0);
    checkOutput("mid_rst_waddr", rf_waddr, 5'd0);
    checkOutput("mid_rst_wdata", rf_wdata, 32'h0);
    checkOutput("mid_rst_pending", pending, 32'h0);
    checkOutput("mid_rst_alu_ready", alu_ready, 1'b0);
    checkOutput("mid_rst_lsu_ready", lsu_ready, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("post_rst_edge_wen", rf_wen, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    idle();
    applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd12, 32'h0000_00F0, 2'd0, LBU, 1'b0, 5'd0);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the NPC core: arbitrates completed results from the ALU path and the LSU load path, aligns and extends load data, and drives the single write port of the register file one cycle after acceptance. It also keeps a per-register pending-load scoreboard for the decode stage's hazard check. Writes to x0 are accepted and discarded.

## Interface

- ADDR_WIDTH, 5, register index width; scoreboard has 2**ADDR_WIDTH bits.
- DATA_WIDTH, 32, register data width; load extension logic is defined for 32 only.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_issue  in  1  a load was issued this cycle; marks lsu_issue_rd pending.
- lsu_issue_rd  in  ADDR_WIDTH  destination of the issued load.
- lsu_valid  in  1  load data returned.
- lsu_ready  out  1  load data accepted this cycle when high with lsu_valid.
- lsu_rd  in  ADDR_WIDTH  load destination register.
- lsu_rdata  in  DATA_WIDTH  raw aligned memory word.
- lsu_addr_lo  in  2  low address bits of the load.
- lsu_funct3  in  3  load type (RV32I encoding).
- rf_wen  out  1  register file write enable, registered.
- rf_waddr  out  ADDR_WIDTH  register file write address, registered.
- rf_wdata  out  DATA_WIDTH  register file write data, registered.
- pending  out  2**ADDR_WIDTH  bit i high while a load to register i is outstanding.

## Operation

- Handshake: transfer occurs on a cycle where valid && ready. Ready is combinational from valid signals and starve counter; valid must not depend on ready. Stage never stalls both sources; at least one is granted whenever any is valid.
- Arbitration: LSU has priority. Starve counter starve_cnt (2 bits): increments when LSU is granted while alu_valid is high; clears when ALU is granted or alu_valid is low. When starve_cnt == 3 and both valid, ALU is granted and LSU waits.
- Grant rules: lsu_ready = lsu_valid && !(alu_valid && starve_cnt == 3); alu_ready = !lsu_ready. Both 0 during rst.
- Load extension by lsu_funct3: 000 LB sign-extend byte at lsu_addr_lo; 001 LH sign-extend half at lsu_addr_lo[1]; 010 LW word unchanged; 100 LBU zero-extend byte; 101 LHU zero-extend half. Any other funct3: word passed unchanged. lsu_addr_lo[0] is ignored for halves.
- x0: a transfer with rd == 0 completes the handshake, but rf_wen stays 0. lsu_issue with rd == 0 does not set a pending bit.
- Scoreboard: bit set on lsu_issue. Bit cleared on the edge where the corresponding LSU write is committed: rf_wen high and the registered source is LSU. If set and clear target the same register on the same edge, set wins. A lsu_issue to an already-pending register leaves the bit set.

## Timing

- Reset values: rf_wen 0, rf_waddr 0, rf_wdata 0, pending all 0, starve_cnt 0, registered source ALU.
- Latency: transfer at edge N drives rf_wen/waddr/wdata during cycle N+1. The register file writes at edge N+1. The pending bit clears at edge N+1, so decode sees the cleared bit in the same cycle the new value is readable.
- Throughput: one writeback per cycle. rf_wen deasserts in any cycle following a cycle with no transfer or with an rd == 0 transfer.
- Reset asserted mid-operation: all state clears immediately; in-flight writeback is dropped; scoreboard is empty after reset.

## Structure

- Package npc_wb_pkg holds the funct3 load constants (LB, LH, LW, LBU, LHU), the source enum (SRC_ALU, SRC_LSU), and STARVE_MAX = 3.
- Sub-module load_ext: combinational extender taking rdata, addr_lo, and funct3, and producing the extended word. Instantiated once.

## Test plan

- Reset: assert rst mid-stream with pending = 0x0000_0100. All outputs become 0 asynchronously, and rf_wen stays 0 on the following edge.
- ALU write: alu_valid, alu_rd = 5, alu_data = 0xDEADBEEF at edge N. Required: rf_wen = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF in cycle N+1. rd = 0 gives rf_wen = 0 while alu_ready is still 1.
- Load extension: lsu_rdata = 0x80FF7F01 with addr_lo = 1. LB gives 0x0000007F. LBU with addr_lo = 2 gives 0x000000FF. LH with addr_lo = 2 gives 0xFFFF80FF. LHU with addr_lo = 0 gives 0x00007F01. LW gives 0x80FF7F01.
- Scoreboard: lsu_issue rd = 8 gives pending[8] = 1. Load data accepted at edge N gives pending[8] = 0 after edge N+1. A simultaneous re-issue to rd = 8 at edge N+1 keeps pending[8] = 1.
- Arbitration: both valid continuously. The grant sequence is LSU, LSU, LSU, ALU, then repeats. When ALU goes idle, starve_cnt clears.
- Back-to-back: 8 consecutive ALU transfers with distinct rd values produce 8 consecutive rf_wen cycles with matching address and data, delayed by one cycle.
